// File: rtl/mux_pkg.sv
// Shared types and constants for the N-channel stream multiplexer.
// Mode encoding, output-stage states and a clog2 helper.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/stream_mux_n_rr_arbiter.sv
// Round-robin arbiter: rotating priority starting at ptr.
// Purely combinational; one-hot grant plus encoded index.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]        req,
  input  logic [clog2(N)-1:0] ptr,
  output logic [N-1:0]        grant,
  output logic [clog2(N)-1:0] idx,
  output logic                any_grant
);

  localparam int SELW = clog2(N);

  always_comb begin
    int j;
    grant     = '0;
    idx       = '0;
    any_grant = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any_grant && req[j]) begin
        any_grant = 1'b1;
        idx       = SELW'(j);
        grant[j]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_n.sv
// N-channel valid/ready stream mux with registered output stage.
// Fixed (sel) or round-robin selection; one word per cycle.
module stream_mux_n
  import mux_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N*W-1:0]      in_data,
  input  logic [N-1:0]        in_valid,
  output logic [N-1:0]        in_ready,
  input  logic [clog2(N)-1:0] sel,
  input  logic                mode,
  output logic [W-1:0]        out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [clog2(N)-1:0] out_chan
);

  localparam int SELW = clog2(N);

  state_e            state;
  logic [SELW-1:0]   ptr;
  logic              live;
  logic              load_en;
  logic              xfer;
  logic              has;
  logic              fix_hit;
  logic [SELW-1:0]   g;
  logic [N-1:0]      onehot;
  logic [N-1:0]      fix_oh;
  logic [N-1:0]      rr_grant;
  logic [SELW-1:0]   rr_idx;
  logic              rr_any;
  logic [W-1:0]      g_data;

  rr_arbiter #(.N(N)) u_arb (
    .req       (in_valid),
    .ptr       (ptr),
    .grant     (rr_grant),
    .idx       (rr_idx),
    .any_grant (rr_any)
  );

  // sel values outside 0..N-1 never match, so they yield no grant
  always_comb begin
    fix_hit = 1'b0;
    fix_oh  = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == SELW'(i) && in_valid[i]) begin
        fix_hit   = 1'b1;
        fix_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    g      = '0;
    has    = 1'b0;
    onehot = '0;
    unique case (mode)
      MODE_RR: begin
        g      = rr_idx;
        has    = rr_any;
        onehot = rr_grant;
      end
      MODE_FIXED: begin
        g      = sel;
        has    = fix_hit;
        onehot = fix_oh;
      end
    endcase
  end

  always_comb begin
    g_data = '0;
    for (int i = 0; i < N; i++)
      if (g == SELW'(i)) g_data = in_data[i*W +: W];
  end

  // live holds off loads on the first edge after reset release
  assign load_en  = live && ((state == ST_EMPTY) || out_ready);
  assign xfer     = has && load_en;
  assign in_ready = load_en ? onehot : '0;
  assign out_valid = (state == ST_FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      out_data <= '0;
      out_chan <= '0;
      ptr      <= '0;
      live     <= 1'b0;
    end else begin
      live <= 1'b1;
      if (xfer) begin
        state    <= ST_FULL;
        out_data <= g_data;
        out_chan <= g;
        if (mode == MODE_RR)
          ptr <= (32'(g) == N - 1) ? '0 : g + 1'b1;
      end else if (state == ST_FULL && out_ready) begin
        state <= ST_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_n.sv
// Directed table-driven bench for stream_mux_n (N=4, W=8).
// Plus hand sequences for reset mid-stream and post-reset latency.
module tb_stream_mux_n;
  import mux_pkg::*;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  in_data;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [1:0]   sel;
  logic         mode;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_chan;

  always #5 clk = ~clk;

  stream_mux_n #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .mode      (mode),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chan  (out_chan)
  );

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic [1:0]  s;
    logic        m;
    logic        ordy;
    logic [3:0]  irdy;
    logic        ov;
    logic [7:0]  od;
    logic [1:0]  oc;
  } vec_t;

  localparam logic [31:0] D0 = 32'h43A5_2110;

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[29];

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] v, input logic [31:0] d,
                              input logic [1:0] s, input logic m,
                              input logic ordy, input logic [3:0] irdy,
                              input logic ov, input logic [7:0] od,
                              input logic [1:0] oc);
    vec_t r;
    r.v = v; r.d = d; r.s = s; r.m = m; r.ordy = ordy;
    r.irdy = irdy; r.ov = ov; r.od = od; r.oc = oc;
    return r;
  endfunction

  initial begin
    // fixed mode, first cycle after release is dead
    tbl[0]  = mk(4'b1111, D0, 2'd2, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0);
    tbl[1]  = mk(4'b1111, D0, 2'd2, 1'b0, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2);
    tbl[2]  = mk(4'b1111, D0, 2'd2, 1'b0, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2);
    tbl[3]  = mk(4'b0111, D0, 2'd3, 1'b0, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2);
    tbl[4]  = mk(4'b0111, D0, 2'd3, 1'b0, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2);
    // round-robin fairness
    tbl[5]  = mk(4'b1111, D0, 2'd3, 1'b1, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0);
    tbl[6]  = mk(4'b1111, D0, 2'd3, 1'b1, 1'b1, 4'b0010, 1'b1, 8'h21, 2'd1);
    tbl[7]  = mk(4'b1111, D0, 2'd3, 1'b1, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2);
    tbl[8]  = mk(4'b1111, D0, 2'd3, 1'b1, 1'b1, 4'b1000, 1'b1, 8'h43, 2'd3);
    tbl[9]  = mk(4'b1111, D0, 2'd3, 1'b1, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0);
    // skip and wrap with ch1/ch3 only
    tbl[10] = mk(4'b1010, D0, 2'd0, 1'b1, 1'b1, 4'b0010, 1'b1, 8'h21, 2'd1);
    tbl[11] = mk(4'b1010, D0, 2'd0, 1'b1, 1'b1, 4'b1000, 1'b1, 8'h43, 2'd3);
    tbl[12] = mk(4'b1010, D0, 2'd0, 1'b1, 1'b1, 4'b0010, 1'b1, 8'h21, 2'd1);
    tbl[13] = mk(4'b1010, D0, 2'd0, 1'b1, 1'b1, 4'b1000, 1'b1, 8'h43, 2'd3);
    // back-pressure with changing inputs
    tbl[14] = mk(4'b0001, 32'h43A52111, 2'd0, 1'b1, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0);
    tbl[15] = mk(4'b1111, 32'h99887755, 2'd1, 1'b0, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd0);
    tbl[16] = mk(4'b1111, 32'h01020304, 2'd3, 1'b1, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd0);
    tbl[17] = mk(4'b1111, 32'hFFFFFFFF, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd0);
    tbl[18] = mk(4'b1111, 32'h5A5A5A5A, 2'd2, 1'b1, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd0);
    tbl[19] = mk(4'b1111, 32'hDEADBEEF, 2'd2, 1'b0, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd0);
    tbl[20] = mk(4'b0001, 32'h43A52122, 2'd0, 1'b0, 1'b1, 4'b0001, 1'b1, 8'h22, 2'd0);
    // mode switch keeps ptr
    tbl[21] = mk(4'b1111, D0, 2'd0, 1'b1, 1'b1, 4'b0010, 1'b1, 8'h21, 2'd1);
    tbl[22] = mk(4'b1111, D0, 2'd0, 1'b0, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0);
    tbl[23] = mk(4'b1111, D0, 2'd0, 1'b1, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2);
    // drain, idle, load while empty and stalled
    tbl[24] = mk(4'b0000, D0, 2'd0, 1'b1, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2);
    tbl[25] = mk(4'b0000, D0, 2'd0, 1'b1, 1'b0, 4'b0000, 1'b0, 8'hA5, 2'd2);
    tbl[26] = mk(4'b0100, D0, 2'd0, 1'b1, 1'b0, 4'b0100, 1'b1, 8'hA5, 2'd2);
    tbl[27] = mk(4'b1111, D0, 2'd0, 1'b1, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd2);
    tbl[28] = mk(4'b0000, D0, 2'd0, 1'b1, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2);

    rst_n = 1'b0; in_valid = '0; in_data = '0;
    sel = '0; mode = MODE_FIXED; out_ready = 1'b0;
    #12;
    chk("rst_ov", 0, 32'(out_valid), 32'd0);
    chk("rst_od", 0, 32'(out_data), 32'd0);
    chk("rst_oc", 0, 32'(out_chan), 32'd0);
    chk("rst_irdy", 0, 32'(in_ready), 32'd0);

    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      if (i == 0) rst_n = 1'b1;
      in_valid = tbl[i].v; in_data = tbl[i].d;
      sel = tbl[i].s; mode = tbl[i].m; out_ready = tbl[i].ordy;
      #1;
      chk("irdy", i, 32'(in_ready), 32'(tbl[i].irdy));
      @(posedge clk);
      #1;
      chk("ov", i, 32'(out_valid), 32'(tbl[i].ov));
      chk("od", i, 32'(out_data), 32'(tbl[i].od));
      chk("oc", i, 32'(out_chan), 32'(tbl[i].oc));
    end

    // mid-stream reset: fill, then assert reset between edges
    @(negedge clk);
    in_valid = 4'b0001; in_data = D0; sel = 2'd0;
    mode = MODE_FIXED; out_ready = 1'b0;
    @(posedge clk); #1;
    chk("fill_ov", 0, 32'(out_valid), 32'd1);
    chk("fill_od", 0, 32'(out_data), 32'h10);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ov", 0, 32'(out_valid), 32'd0);
    chk("arst_od", 0, 32'(out_data), 32'd0);
    chk("arst_oc", 0, 32'(out_chan), 32'd0);
    chk("arst_irdy", 0, 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 4'b1111; mode = MODE_RR; out_ready = 1'b1;
    #1;
    chk("rel_irdy", 0, 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("rel_ov", 0, 32'(out_valid), 32'd0);
    @(negedge clk); #1;
    chk("rel_irdy", 1, 32'(in_ready), 32'b0001);
    @(posedge clk); #1;
    chk("rel_ov", 1, 32'(out_valid), 32'd1);
    chk("rel_od", 1, 32'(out_data), 32'h10);
    chk("rel_oc", 1, 32'(out_chan), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stream_mux_n.md
# stream_mux_n

Parametrised N-channel, W-bit valid/ready stream multiplexer with a registered output stage and two selection modes: externally selected (fixed) or round-robin. It is the sequential successor to the team's combinational 4:1 mux. It sits between several producer streams and one consumer, and adds flow control, back-pressure and fair arbitration that a plain select mux lacks.

## Interface
- N, 4, number of input channels (2..16)
- W, 8, data width per channel (1..64)
- SELW, $clog2(N), derived localparam, channel index width; not overridable
- clk  input  1  rising-edge clock, the only clock
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  N*W  packed channel data; channel i occupies bits [i*W +: W]
- in_valid  input  N  per-channel valid
- in_ready  output  N  per-channel ready, at most one bit set per cycle
- sel  input  SELW  channel index used in fixed mode
- mode  input  1  0 = fixed (MODE_FIXED), 1 = round-robin (MODE_RR)
- out_data  output  W  registered selected data
- out_valid  output  1  output holds a word
- out_ready  input  1  consumer accepts the word
- out_chan  output  SELW  index of the channel that supplied out_data

## Operation
- Output-stage FSM has two states. It leaves reset in EMPTY.
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- load_en = (state==EMPTY) || out_ready.
- Grant decision, evaluated combinationally every cycle:
  - Fixed mode: grant=sel when in_valid[sel]=1. Otherwise there is no grant; other channels are never granted.
  - RR mode: grant is the first i with in_valid[i]=1, searching ptr, ptr+1, …, N-1, 0, …, ptr-1. There is no grant when in_valid is all zero.
  - A sel value ≥ N is treated as no grant.
- in_ready[g]=load_en for the granted channel g. All other in_ready bits are 0.
- Transfer on channel g occurs when in_valid[g] && in_ready[g]. On the next edge:
  - out_data ← in_data[g]
  - out_chan ← g
  - state ← FULL
- FULL && out_ready && no transfer: state ← EMPTY on the next edge. out_data and out_chan hold their last values.
- FULL && !out_ready: out_data and out_chan are held stable, and all in_ready are 0.
- RR pointer:
  - After each transfer in RR mode, ptr ← (g+1) mod N. From g=N-1 it wraps to 0.
  - ptr is not updated in fixed mode.
  - ptr is preserved across mode changes.
- mode and sel are sampled only at the grant decision. Changing them while FULL and stalled has no effect on the held word.
- Simultaneous drain and load (FULL, out_ready=1, transfer): state stays FULL and the new word replaces the old one. This gives one word per cycle with no bubble.

## Timing
- Reset values, forced asynchronously on rst_n=0: out_valid=0, out_data=0, out_chan=0, ptr=0, state=EMPTY. in_ready=0 during reset because load_en is forced low.
- Reset released mid-stream: any held word is discarded, and no transfer occurs on the first edge after deassertion.
- Latency is 1 cycle from input transfer to out_valid.
- Sustained throughput is 1 word per cycle with out_ready held at 1.
- in_ready depends combinationally on out_ready, in_valid, sel, mode and ptr. It does not depend on in_data. There is no combinational path from in_data to out_data.
- Single-cycle glitches on non-granted in_valid bits have no effect.

## Structure
- Package mux_pkg holds:
  - MODE_FIXED=1'b0 and MODE_RR=1'b1
  - the output-stage state encoding (ST_EMPTY, ST_FULL)
  - a clog2 helper function for tools lacking $clog2
- Sub-module rr_arbiter (parameter N) takes req[N] and ptr[SELW]. It produces a one-hot grant[N], a grant index and any_grant. It is purely combinational; the rotate-and-priority-encode logic lives here.
- stream_mux_n holds the FSM, the ptr register, the output register, and fixed/RR grant selection.
- Target size is about 150–250 lines of RTL in total.

## Test plan
- Reset: assert rst_n=0 mid-stream with out_valid=1. out_valid=0, out_data=0 and out_chan=0 occur immediately, with no clock edge needed. After release, the first word appears no earlier than 2 edges later.
- Fixed mode, N=4, W=8, sel=2, in_valid=4'b1111, in_data ch2=8'hA5, out_ready=1:
  - out_data=8'hA5, out_chan=2 one cycle later
  - in_ready=4'b0100
  - then sel=3 with in_valid[3]=0 → in_ready=0 and out_valid drops after drain
- RR fairness: all four channels valid continuously, out_ready=1 → out_chan sequence 0,1,2,3,0,1,… with one word per cycle and no bubbles.
- RR skip and wrap: only ch1 and ch3 valid, ptr=0 → grants 1,3,1,3. ptr after the ch3 grant wraps to 0.
- Back-pressure: FULL with out_data=8'h11 and out_ready=0 for 5 cycles while in_data, sel and mode change:
  - out_data, out_chan and out_valid stay stable and all in_ready=0
  - releasing out_ready with ch0 valid (8'h22) gives out_data=8'h22 on the next edge with no empty cycle
- Mode switch: RR after granting ch1 (ptr=2), switch to fixed with sel=0 → ch0 served. Switch back to RR → next grant is ch2, confirming ptr was preserved.
